// File: rtl/optical_4x4_state_decoder.sv
// Readback decoder for the 4x4 bar/cross switch: settle, decode the state word, compare, report.
// Define OPT_DEC_STATS_EN to add saturating handshake/mismatch/error counters.
module optical_4x4_state_decoder #(
    parameter logic P_BAR           = 1'b0,
    parameter logic P_CROSS         = 1'b1,
    parameter int   P_SETTLE_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_switch_grant,
    input  logic       i_grant_valid,
    input  logic [7:0] i_expect_config,
    input  logic       i_expect_valid,
    output logic [7:0] o_decode_config,
    output logic       o_decode_error,
    output logic       o_match,
    output logic       o_decode_valid,
    input  logic       i_decode_ready,
    output logic       o_busy,
    output logic       o_overrun
`ifdef OPT_DEC_STATS_EN
    ,
    output logic [15:0] o_stat_decodes,
    output logic [15:0] o_stat_mismatch,
    output logic [15:0] o_stat_errors
`endif
);

    localparam logic [7:0] L_SETTLE = 8'(P_SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, REPORT} state_t;

    state_t     state_q, state_d;
    logic [3:0] capture_q, capture_d;
    logic [3:0] pending_q, pending_d;
    logic       pending_full_q, pending_full_d;
    logic [7:0] count_q, count_d;
    logic [7:0] expect_q, expect_d;
    logic       expect_seen_q, expect_seen_d;
    logic [7:0] config_q, config_d;
    logic       error_q, error_d;
    logic       match_q, match_d;
    logic       overrun_q, overrun_d;

    logic [3:0] norm_w;
    logic [7:0] dec_cfg;
    logic       dec_err;
    logic       handshake;

    assign handshake = (state_q == REPORT) && i_decode_ready;

    // Normalise so that a 1 always means "cross" regardless of fabric polarity.
    always_comb begin
        norm_w  = (P_CROSS == 1'b1) ? capture_q : ~capture_q;
        dec_cfg = 8'h00;
        dec_err = 1'b0;
        case (norm_w)
            4'b0000: dec_cfg = 8'h4E;
            4'b0001: dec_cfg = 8'h4B;
            4'b0100: dec_cfg = 8'h8D;
            4'b0101: dec_cfg = 8'hC9;
            4'b0110: dec_cfg = 8'h87;
            4'b0111: dec_cfg = 8'hC6;
            4'b1000: dec_cfg = 8'h72;
            4'b1001: dec_cfg = 8'h63;
            4'b1010: dec_cfg = 8'h78;
            4'b1011: dec_cfg = 8'h6C;
            4'b1100: dec_cfg = 8'hB1;
            4'b1101: dec_cfg = 8'hE1;
            4'b1110: dec_cfg = 8'hB4;
            4'b1111: dec_cfg = 8'hE4;
            default: dec_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        capture_d      = capture_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        count_d        = count_q;
        expect_d       = expect_q;
        expect_seen_d  = expect_seen_q;
        config_d       = config_q;
        error_d        = error_q;
        match_d        = match_q;
        overrun_d      = overrun_q;

        if (i_expect_valid) begin
            expect_d      = i_expect_config;
            expect_seen_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (i_grant_valid) begin
                    capture_d = i_switch_grant;
                    count_d   = L_SETTLE;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (i_grant_valid) begin
                    capture_d = i_switch_grant;
                    count_d   = L_SETTLE;
                end else begin
                    count_d = count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        config_d = dec_cfg;
                        error_d  = dec_err;
                        match_d  = !dec_err && expect_seen_q && (dec_cfg == expect_q);
                        state_d  = REPORT;
                    end
                end
            end
            REPORT: begin
                if (i_grant_valid) begin
                    if (pending_full_q)
                        overrun_d = 1'b1;
                    pending_d      = i_switch_grant;
                    pending_full_d = 1'b1;
                end
                // A grant on the handshake edge goes through the slot and straight out again.
                if (handshake) begin
                    pending_full_d = 1'b0;
                    if (i_grant_valid || pending_full_q) begin
                        capture_d = i_grant_valid ? i_switch_grant : pending_q;
                        count_d   = L_SETTLE;
                        state_d   = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= IDLE;
            capture_q      <= 4'h0;
            pending_q      <= 4'h0;
            pending_full_q <= 1'b0;
            count_q        <= 8'h00;
            expect_q       <= 8'h00;
            expect_seen_q  <= 1'b0;
            config_q       <= 8'h00;
            error_q        <= 1'b0;
            match_q        <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            capture_q      <= capture_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            count_q        <= count_d;
            expect_q       <= expect_d;
            expect_seen_q  <= expect_seen_d;
            config_q       <= config_d;
            error_q        <= error_d;
            match_q        <= match_d;
            overrun_q      <= overrun_d;
        end
    end

    assign o_decode_config = config_q;
    assign o_decode_error  = error_q;
    assign o_match         = match_q;
    assign o_decode_valid  = (state_q == REPORT);
    assign o_busy          = (state_q != IDLE);
    assign o_overrun       = overrun_q;

`ifdef OPT_DEC_STATS_EN
    logic [15:0] stat_decodes_q, stat_decodes_d;
    logic [15:0] stat_mismatch_q, stat_mismatch_d;
    logic [15:0] stat_errors_q, stat_errors_d;

    always_comb begin
        stat_decodes_d  = stat_decodes_q;
        stat_mismatch_d = stat_mismatch_q;
        stat_errors_d   = stat_errors_q;
        if (handshake) begin
            if (stat_decodes_q != 16'hFFFF)
                stat_decodes_d = stat_decodes_q + 16'd1;
            if (!match_q && expect_seen_q && (stat_mismatch_q != 16'hFFFF))
                stat_mismatch_d = stat_mismatch_q + 16'd1;
            if (error_q && (stat_errors_q != 16'hFFFF))
                stat_errors_d = stat_errors_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stat_decodes_q  <= 16'h0000;
            stat_mismatch_q <= 16'h0000;
            stat_errors_q   <= 16'h0000;
        end else begin
            stat_decodes_q  <= stat_decodes_d;
            stat_mismatch_q <= stat_mismatch_d;
            stat_errors_q   <= stat_errors_d;
        end
    end

    assign o_stat_decodes  = stat_decodes_q;
    assign o_stat_mismatch = stat_mismatch_q;
    assign o_stat_errors   = stat_errors_q;
`endif

endmodule

// File: doc/optical_4x4_state_decoder.md
Name: optical_4x4_state_decoder

Overview:
- Inverse/readback end of the 4x4 optical switch configuration path.
- Takes the 4-bit bar/cross switch-state word returned by the switch fabric and waits a programmable settling time.
- Decodes that word back into the 8-bit routing permutation, checks it against the most recently requested configuration, and presents the result to the controller over a valid/ready handshake.

Parameters:
- P_BAR, 1'b0: switch-state bit value meaning "bar".
- P_CROSS, 1'b1: switch-state bit value meaning "cross". Must differ from P_BAR.
- P_SETTLE_CYCLES, 16: clocks to wait after capture before decoding. Legal range 1..255.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous, active-high reset
- i_switch_grant  input  4  switch-state word, bits [3:0]
- i_grant_valid  input  1  single-cycle strobe; i_switch_grant is valid
- i_expect_config  input  8  requested permutation {d3,d2,d1,d0}, 2 bits each, [7:6]..[1:0]
- i_expect_valid  input  1  strobe; latch i_expect_config
- o_decode_config  output  8  decoded permutation, same field layout
- o_decode_error  output  1  state word has no legal permutation
- o_match  output  1  decoded == expected, error clear, and an expectation has been latched since reset
- o_decode_valid  output  1  result valid
- i_decode_ready  input  1  consumer accepts the result
- o_busy  output  1  state is not IDLE
- o_overrun  output  1  sticky; a pending capture was overwritten

Behaviour:
- Single clock; reset is synchronous and active-high on i_rst, sampled at the i_clk rising edge.
- Reset values:
  - all outputs 0
  - FSM in IDLE
  - expect-seen flag clear
  - pending slot empty
  - settle counter 0
- Normalisation: w = i_switch_grant when P_CROSS=1, else ~i_switch_grant, so that 1 = cross.
- Decode table, w -> {d3,d2,d1,d0}:
  - 0001->1023, 0000->1032, 1001->1203, 1011->1230, 1000->1302, 1010->1320, 0110->2013
  - 0100->2031, 1100->2301, 1110->2310, 0111->3012, 0101->3021, 1101->3201, 1111->3210
  - w=0010 or 0011: o_decode_config=8'h00, o_decode_error=1, o_match=0.
- Expectation register:
  - loads i_expect_config on any cycle with i_expect_valid=1, in any state, and sets expect-seen.
  - Compare uses the register value at the REPORT entry edge.
- FSM states: IDLE, SETTLE, REPORT.
  - IDLE, i_grant_valid=1: capture the word, load the counter with P_SETTLE_CYCLES, go to SETTLE.
  - SETTLE: decrement each clock.
    - At count 1 -> 0, register the decode and compare results and go to REPORT.
    - i_grant_valid in SETTLE recaptures the word and reloads the counter (latest wins, no overrun).
  - REPORT: o_decode_valid=1. o_decode_config, o_decode_error and o_match are held stable until i_decode_ready=1.
    - On the handshake edge: if the pending slot is full, move it into the capture register, reload the counter, go to SETTLE; else go to IDLE.
    - o_decode_valid falls in the cycle after the handshake.
- Latency: P_SETTLE_CYCLES+1 clocks from the edge sampling i_grant_valid to the first cycle with o_decode_valid=1 (17 at default).
- Pending slot:
  - i_grant_valid in REPORT stores the word in a one-deep pending slot.
  - If the slot is already full, overwrite it and set o_overrun (cleared only by reset).
  - i_grant_valid on the handshake edge counts as a REPORT-state arrival: pending is loaded, then consumed immediately.
- i_decode_ready outside REPORT: ignored.
- Reset mid-operation: abandon any in-flight result. o_decode_valid drops on the next cycle; pending is discarded.

Optional Feature:
- Macro: OPT_DEC_STATS_EN.
- Defined: adds output ports o_stat_decodes[15:0], o_stat_mismatch[15:0] and o_stat_errors[15:0].
  - Each counts accepted handshakes: all, those with o_match=0 and expect-seen=1, and those with o_decode_error=1.
  - Counters saturate at 16'hFFFF and are cleared by i_rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, i_expect_config=8'h4B (1023), then i_switch_grant=4'b0001 with ready tied high -> o_decode_valid for one cycle 17 clocks later, o_decode_config=8'h4B, o_match=1, o_decode_error=0.
- i_switch_grant=4'b0010 -> o_decode_error=1, o_decode_config=8'h00, o_match=0. Repeat with 4'b0011.
- Expect 8'hE4 (3210), grant 4'b1101 (3201) -> o_decode_config=8'hE1, o_match=0. Grant with no expectation since reset -> o_match=0.
- Hold ready low 10 cycles in REPORT and send two grants (0110, then 1100) -> outputs stable throughout, o_overrun=1. After ready, the next result is 2301 (8'hB1) after 17 clocks.
- Second grant 5 cycles into SETTLE -> counter restarts, single result for the second word 17 clocks after it. Assert i_rst during SETTLE -> no o_decode_valid appears.
- Instantiate with P_BAR=1, P_CROSS=0 and send 4'b1110 -> decodes as w=0001, giving 8'h4B.
